// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, FSM encoding and latency shared by ex_muldiv, the hazard unit and benches.
package mips_pkg;
    localparam int MULDIV_WIDTH   = 32;
    localparam int MULDIV_LATENCY = MULDIV_WIDTH + 2;
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_SIGN} state_e;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring-divide iteration on {hi, lo} accumulator.
// The divide path exists only when MULDIV_DIV_EN is defined.
module muldiv_step #(
    parameter int W = 32
) (
`ifdef MULDIV_DIV_EN
    input  logic           mode_i,
`endif
    input  logic [2*W-1:0] acc_i,
    input  logic [W-1:0]   b_i,
    output logic [2*W-1:0] acc_o
);
    logic [W:0] sum;
    assign sum = {1'b0, acc_i[2*W-1:W]} + (acc_i[0] ? {1'b0, b_i} : '0);
`ifdef MULDIV_DIV_EN
    logic [W:0] trial;
    // Trial subtract of the shifted partial remainder; a borrow restores it.
    assign trial = acc_i[2*W-1:W-1] - {1'b0, b_i};
    assign acc_o = !mode_i ? {sum, acc_i[W-1:1]}
                 : trial[W] ? {acc_i[2*W-2:0], 1'b0}
                 : {trial[W-1:0], acc_i[W-2:0], 1'b1};
`else
    assign acc_o = {sum, acc_i[W-1:1]};
`endif
endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, stalling the pipe via o_busy.
// Division (DIV/DIVU, o_div_zero) is built only when MULDIV_DIV_EN is defined.
module ex_muldiv #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [2:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_regA,
    input  logic [DATA_WIDTH-1:0] i_regB,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_div_zero,
    output logic [DATA_WIDTH-1:0] o_hi,
    output logic [DATA_WIDTH-1:0] o_lo
);
    import mips_pkg::*;
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2*W-1:0] acc_q, acc_d, step_acc, prod;
    logic [W-1:0] b_q, b_d, hi_q, hi_d, lo_q, lo_d, a_abs, b_abs;
    logic neg_q, neg_d, done_q, done_d;
    logic accept, is_mul, is_div, sgn, div_zero;
`ifdef MULDIV_DIV_EN
    logic mode_q, mode_d, rneg_q, rneg_d, dz_q, dz_d;
    assign is_div = i_op == OP_DIV || i_op == OP_DIVU;
    assign sgn    = i_op == OP_MULT || i_op == OP_DIV;
    assign o_div_zero = dz_q;
`else
    assign is_div = 1'b0;
    assign sgn    = i_op == OP_MULT;
    assign o_div_zero = 1'b0;
`endif
    assign accept   = state_q == S_IDLE && i_start;
    assign is_mul   = i_op == OP_MULT || i_op == OP_MULTU;
    assign div_zero = is_div && i_regB == '0;
    assign a_abs    = sgn && i_regA[W-1] ? -i_regA : i_regA;
    assign b_abs    = sgn && i_regB[W-1] ? -i_regB : i_regB;
    assign prod     = neg_q ? -acc_q : acc_q;
    assign o_busy   = state_q != S_IDLE;
    assign o_done   = done_q;
    assign o_hi     = hi_q;
    assign o_lo     = lo_q;
    muldiv_step #(.W(W)) u_step (
`ifdef MULDIV_DIV_EN
        .mode_i(mode_q),
`endif
        .acc_i(acc_q),
        .b_i(b_q),
        .acc_o(step_acc)
    );
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        b_d     = b_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
`ifdef MULDIV_DIV_EN
        mode_d  = mode_q;
        rneg_d  = rneg_q;
        dz_d    = 1'b0;
`endif
        if (accept && (is_mul || (is_div && !div_zero))) begin
            state_d = S_RUN;
            cnt_d   = CW'(W - 1);
            // Multiplier (or dividend) sits in the low half and is consumed one bit per cycle.
            acc_d   = {{W{1'b0}}, is_mul ? b_abs : a_abs};
            b_d     = is_mul ? a_abs : b_abs;
            neg_d   = sgn && (i_regA[W-1] ^ i_regB[W-1]);
`ifdef MULDIV_DIV_EN
            mode_d  = is_div;
            rneg_d  = sgn && i_regA[W-1];
`endif
        end else if (accept) begin
            hi_d   = i_op == OP_MTHI ? i_regA : hi_q;
            lo_d   = i_op == OP_MTLO ? i_regA : lo_q;
            done_d = div_zero;
`ifdef MULDIV_DIV_EN
            dz_d   = div_zero;
`endif
        end else if (state_q == S_RUN) begin
            acc_d   = step_acc;
            cnt_d   = cnt_q - CW'(1);
            state_d = cnt_q == '0 ? S_SIGN : S_RUN;
        end else if (state_q == S_SIGN) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
`ifdef MULDIV_DIV_EN
            hi_d = mode_q ? (rneg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W]) : prod[2*W-1:W];
            lo_d = mode_q ? (neg_q ? -acc_q[W-1:0] : acc_q[W-1:0]) : prod[W-1:0];
`else
            hi_d = prod[2*W-1:W];
            lo_d = prod[W-1:0];
`endif
        end
    end
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
            mode_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
`ifdef MULDIV_DIV_EN
            mode_q  <= mode_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
`endif
        end
    end
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide unit for the EX stage, directly downstream of the ID/EX pipeline register. It consumes the operand pair and a mul/div opcode launched from ID/EX, computes over multiple cycles while holding a stall request, and writes the architectural HI/LO registers. MFHI/MFLO read HI/LO through the forwarding path.

## Interface
Parameters:
- DATA_WIDTH, 32, operand and HI/LO width; even, ≥ 8.

Ports:
- i_clock  in  1  rising-edge clock
- i_reset  in  1  synchronous, active-low reset
- i_start  in  1  launch request, valid for one cycle; sampled only in IDLE
- i_op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored
- i_regA  in  DATA_WIDTH  rs operand: multiplicand/dividend, or MTHI/MTLO source
- i_regB  in  DATA_WIDTH  rt operand: multiplier/divisor
- o_busy  out  1  stall request to hazard unit; high while state ≠ IDLE
- o_done  out  1  one-cycle pulse; new HI/LO visible in that cycle
- o_div_zero  out  1  one-cycle pulse with o_done when divisor was zero
- o_hi  out  DATA_WIDTH  HI register
- o_lo  out  DATA_WIDTH  LO register

## Operation
- Reset (i_reset=0 at a clock edge): state IDLE, o_hi = o_lo = 0, o_busy = o_done = o_div_zero = 0, counter 0. Any in-flight operation is discarded.
- FSM states: IDLE, RUN, SIGN.
  - IDLE → RUN when i_start is high with a MULT/MULTU/DIV/DIVU opcode and a nonzero divisor.
  - RUN → SIGN after DATA_WIDTH iterations (counter DATA_WIDTH-1 down to 0).
  - SIGN → IDLE always.
- Accept: latch opcode. Latch |regA| and |regB| for signed ops, raw values for unsigned ops. Record the result sign flags.
- Multiply: shift-add, one multiplier bit per RUN cycle, into a 2·DATA_WIDTH accumulator.
  - SIGN: negate the full 2·DATA_WIDTH product if the operand signs differ (MULT only).
  - Result: HI = upper half, LO = lower half.
- Divide: restoring, one quotient bit per RUN cycle.
  - SIGN (DIV only): negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
  - Result: LO = quotient, HI = remainder.
  - 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0 with no trap.
- Divide by zero (DIV/DIVU with i_regB = 0):
  - No RUN. HI/LO unchanged.
  - o_done and o_div_zero pulse in the cycle after accept. o_busy stays low.
- MTHI/MTLO in IDLE with i_start: HI (or LO) ← i_regA at that edge. No busy, no done.
- i_start while busy is ignored; the hazard unit must hold ID/EX using o_busy.
- Undefined opcodes (110/111) are ignored.

## Timing
- Start sampled at edge ending cycle t.
- Cycles t+1 … t+DATA_WIDTH: RUN. Cycle t+DATA_WIDTH+1: SIGN. o_busy is high for all of t+1 … t+DATA_WIDTH+1.
- HI/LO are written at the edge ending SIGN.
- Cycle t+DATA_WIDTH+2: o_done = 1 and o_busy = 0. A new i_start is accepted in this cycle, giving back-to-back throughput of DATA_WIDTH+2 cycles.
- o_done and o_div_zero are registered. o_busy is decoded from the state register.

## Configuration
- MULDIV_DIV_EN defined: full behaviour above.
- Not defined:
  - Divider datapath and quotient logic are removed.
  - DIV/DIVU are ignored like undefined opcodes: no busy, no done, HI/LO unchanged.
  - o_div_zero is tied to 0.

## Structure
- Shared package mips_pkg holds:
  - opcode localparams (OP_MULT … OP_MTLO)
  - the FSM state encoding
  - the MULDIV_LATENCY constant (DATA_WIDTH+2) used by the hazard unit and the bench
- One sub-module, muldiv_step: combinational single iteration (shift-add or restore-subtract selected by a mode bit). The FSM, counter and HI/LO stay in ex_muldiv.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001; o_done exactly 34 cycles after start; o_busy high for the 33 cycles before.
- MULT 0xFFFFFFFD (−3) × 7 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB; then MTHI 0x12345678 → HI = 0x12345678 next cycle, LO unchanged, no o_done.
- DIVU 100 / 7 → LO = 14, HI = 2. DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0. DIVU 5 / 0 → o_done and o_div_zero at t+1, HI/LO unchanged, o_busy never high.
- i_start with MULTU 3×3 during RUN of a prior MULT → ignored; only the first result appears.
- Reset low at RUN cycle 10 → next cycle o_busy = 0, HI = LO = 0, no o_done. Without MULDIV_DIV_EN, DIVU 100 / 7 → no busy, no done, HI/LO unchanged.
